// File: rtl/nibble_serial_adder_if.sv
// nibble_serial_adder_if: operand/result handshake bundle for nibble_serial_adder.
// The ovf signal exists only when OVF_FLAG_EN is defined.
interface nibble_serial_adder_if #(parameter int W = 16);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
`ifdef OVF_FLAG_EN
    logic         ovf;
    modport master (output in_valid, a, b, cin, out_ready,
                    input in_ready, out_valid, sum, cout, busy, ovf);
    modport slave  (input in_valid, a, b, cin, out_ready,
                    output in_ready, out_valid, sum, cout, busy, ovf);
`else
    modport master (output in_valid, a, b, cin, out_ready,
                    input in_ready, out_valid, sum, cout, busy);
    modport slave  (input in_valid, a, b, cin, out_ready,
                    output in_ready, out_valid, sum, cout, busy);
`endif
endinterface

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: adds two 4*NIBBLES-bit operands one nibble per clock, LSB first.
// Define OVF_FLAG_EN to add the signed-overflow flag (bus.ovf).
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    nibble_serial_adder_if.slave bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q;
    logic [W-1:0]    a_sr_q;
    logic [W-1:0]    b_sr_q;
    logic [W-1:0]    sum_q;
    logic [IW-1:0]   idx_q;
    logic            carry_q;
    logic            cout_q;
    logic [4:0]      nib_d;
    logic            last_d;

    always_comb begin
        nib_d  = 5'(a_sr_q[3:0]) + 5'(b_sr_q[3:0]) + 5'(carry_q);
        last_d = (idx_q == IW'(NIBBLES - 1));
    end

`ifdef OVF_FLAG_EN
    logic ovf_q;
    assign bus.ovf = ovf_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef OVF_FLAG_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    a_sr_q  <= bus.a;
                    b_sr_q  <= bus.b;
                    carry_q <= bus.cin;
                    idx_q   <= '0;
                    sum_q   <= '0;
                    state_q <= RUN;
                end
                RUN: begin
                    sum_q[4*int'(idx_q) +: 4] <= nib_d[3:0];
                    carry_q <= nib_d[4];
                    a_sr_q  <= a_sr_q >> 4;
                    b_sr_q  <= b_sr_q >> 4;
                    idx_q   <= last_d ? idx_q : idx_q + IW'(1);
                    if (last_d) begin
                        cout_q  <= nib_d[4];
`ifdef OVF_FLAG_EN
                        // carry into the MSB is recovered from its sum bit
                        ovf_q   <= a_sr_q[3] ^ b_sr_q[3] ^ nib_d[3] ^ nib_d[4];
`endif
                        state_q <= DONE;
                    end
                end
                DONE: if (bus.out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == RUN);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed scoreboard bench for NIBBLES=4 and NIBBLES=1 instances.
// Expected results are queued at accept and checked when the result handshake appears.
module tb_nibble_serial_adder;
    localparam int N  = 4;
    localparam int W  = 4 * N;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nibble_serial_adder_if #(.W(W)) if0 ();
    nibble_serial_adder_if #(.W(4)) if1 ();

    nibble_serial_adder #(.NIBBLES(N)) dut  (.clk(clk), .rst_n(rst_n), .bus(if0));
    nibble_serial_adder #(.NIBBLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    exp_t q[$];
    exp_t q1[$];
    exp_t last;
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        exp_t e;
        logic [W:0] full;
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        e.s = full[W-1:0];
        e.c = full[W];
        e.o = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        return e;
    endfunction

    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        if0.a = a;
        if0.b = b;
        if0.cin = c;
        if0.in_valid = 1'b1;
        chk("in_ready_before_accept", 64'(if0.in_ready), 64'd1);
        q.push_back(model(a, b, c));
        @(negedge clk);
        if0.in_valid = 1'b0;
        chk("busy_after_accept", 64'(if0.busy), 64'd1);
    endtask

    // out_valid must be low after N clocks (counting the accept edge) and high after N+1
    task automatic expect_result(input string tag);
        repeat (N - 1) @(negedge clk);
        chk({tag, "_valid_early"}, 64'(if0.out_valid), 64'd0);
        @(negedge clk);
        chk({tag, "_valid"}, 64'(if0.out_valid), 64'd1);
        chk({tag, "_sb_depth"}, 64'(q.size()), 64'd1);
        if (q.size() != 0) begin
            last = q.pop_front();
            chk({tag, "_sum"}, 64'(if0.sum), 64'(last.s));
            chk({tag, "_cout"}, 64'(if0.cout), 64'(last.c));
`ifdef OVF_FLAG_EN
            chk({tag, "_ovf"}, 64'(if0.ovf), 64'(last.o));
`endif
        end
    endtask

    task automatic handshake(input string tag);
        if0.out_ready = 1'b1;
        @(negedge clk);
        if0.out_ready = 1'b0;
        chk({tag, "_valid_dropped"}, 64'(if0.out_valid), 64'd0);
        chk({tag, "_in_ready"}, 64'(if0.in_ready), 64'd1);
    endtask

    initial begin
        int n_valid;
        if0.in_valid = 1'b0; if0.a = '0; if0.b = '0; if0.cin = 1'b0; if0.out_ready = 1'b0;
        if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0; if1.out_ready = 1'b0;
        #1;
        chk("rst_in_ready", 64'(if0.in_ready), 64'd1);
        chk("rst_out_valid", 64'(if0.out_valid), 64'd0);
        chk("rst_sum", 64'(if0.sum), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        accept(16'h1234, 16'h4321, 1'b0);
        expect_result("add_5555");
        handshake("add_5555");

        accept(16'hFFFF, 16'h0000, 1'b1);
        expect_result("ripple");
        handshake("ripple");

`ifdef OVF_FLAG_EN
        accept(16'h7FFF, 16'h0001, 1'b0);
        expect_result("ovf_pos");
        handshake("ovf_pos");
        accept(16'hFFFF, 16'h0001, 1'b0);
        expect_result("ovf_none");
        handshake("ovf_none");
`endif

        // backpressure: result held while a new request waits
        accept(16'hA5C3, 16'h5A3C, 1'b1);
        expect_result("bp");
        if0.a = 16'h0F0F; if0.b = 16'h0101; if0.cin = 1'b0; if0.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", 64'(if0.out_valid), 64'd1);
            chk("bp_hold_in_ready", 64'(if0.in_ready), 64'd0);
            chk("bp_hold_sum", 64'(if0.sum), 64'(last.s));
        end
        handshake("bp");
        accept(16'h0F0F, 16'h0101, 1'b0);
        expect_result("bp_next");
        handshake("bp_next");

        // leave a cout=1 result behind, then reset in the middle of the next run
        accept(16'hFFFF, 16'h0001, 1'b0);
        expect_result("pre_rst");
        handshake("pre_rst");
        accept(16'h8888, 16'h8888, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        q.delete();
        chk("midrst_out_valid", 64'(if0.out_valid), 64'd0);
        chk("midrst_sum", 64'(if0.sum), 64'd0);
        chk("midrst_cout", 64'(if0.cout), 64'd0);
        chk("midrst_busy", 64'(if0.busy), 64'd0);
        chk("midrst_in_ready", 64'(if0.in_ready), 64'd1);
`ifdef OVF_FLAG_EN
        chk("midrst_ovf", 64'(if0.ovf), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        if0.out_ready = 1'b1;
        accept(16'h0001, 16'h0001, 1'b0);
        expect_result("post_rst");
        chk("post_rst_expected", 64'(last.s), 64'h0002);
        handshake("post_rst");

        // NIBBLES=1: two-clock latency then back-to-back throughput
        if1.a = 4'h9; if1.b = 4'h8; if1.cin = 1'b1; if1.in_valid = 1'b1;
        @(negedge clk);
        if1.in_valid = 1'b0;
        chk("n1_valid_early", 64'(if1.out_valid), 64'd0);
        @(negedge clk);
        chk("n1_valid", 64'(if1.out_valid), 64'd1);
        chk("n1_sum", 64'(if1.sum), 64'h2);
        chk("n1_cout", 64'(if1.cout), 64'd1);
        if1.out_ready = 1'b1;
        @(negedge clk);
        n_valid = 0;
        for (int i = 0; i < 12; i++) begin
            if (if1.out_valid) begin
                n_valid++;
                if (q1.size() == 0) chk("n1_sb_depth", 64'(q1.size()), 64'd1);
                else begin
                    last = q1.pop_front();
                    chk("n1_b2b_sum", 64'(if1.sum), 64'(last.s[3:0]));
                    chk("n1_b2b_cout", 64'(if1.cout), 64'(last.c));
                end
            end
            if (if1.in_ready) begin
                exp_t e;
                logic [4:0] f;
                if1.a = 4'($urandom_range(15));
                if1.b = 4'($urandom_range(15));
                if1.cin = 1'($urandom_range(1));
                f = 5'(if1.a) + 5'(if1.b) + 5'(if1.cin);
                e.s = W'(f[3:0]);
                e.c = f[4];
                e.o = 1'b0;
                q1.push_back(e);
            end
            if1.in_valid = 1'b1;
            @(negedge clk);
        end
        chk("n1_throughput", 64'(n_valid), 64'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
